// File: rtl/seq_player.sv
// seq_player
//   Sequencer that walks a combinational 4-bit sequence ROM (seq_00 family)
//   from address 0 up to LAST, captures each ROM word into a register and
//   hands it downstream over a valid/ready handshake. Playback can be
//   one-shot or looping, can be stopped early, and tolerates back-pressure
//   without skipping or repeating a word.
//
// Parameters
//   SIZE    width of the ROM address and data
//   LAST    last address played before wrap or end (0 .. 2**SIZE-1)
//
// Ports
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   start    in   begin playback (only looked at while idle)
//   loop     in   at the LAST capture: 1 = wrap to 0, 0 = finish
//   parar    in   stop request while running
//   address  out  registered ROM address
//   saida    in   ROM data for the current address
//   dado     out  captured word for downstream
//   valido   out  dado is valid
//   pronto   in   downstream takes dado when valido && pronto
//   ocupado  out  high whenever not idle
//   fim      out  one-cycle pulse on the first idle cycle after playback
module seq_player #(
  parameter int SIZE = 4,
  parameter int LAST = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            loop,
  input  logic            parar,
  output logic [SIZE-1:0] address,
  input  logic [SIZE-1:0] saida,
  output logic [SIZE-1:0] dado,
  output logic            valido,
  input  logic            pronto,
  output logic            ocupado,
  output logic            fim
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [SIZE-1:0] LAST_A = SIZE'(LAST);
  localparam logic [SIZE-1:0] ZERO_A = '0;
  localparam logic [SIZE-1:0] ONE_A  = SIZE'(1);

  state_t state;
  logic   cap;

  // The output register is free when it is empty or being taken this edge;
  // capturing into it only then keeps every ROM word seen exactly once.
  assign cap     = !valido || pronto;
  assign ocupado = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      address <= ZERO_A;
      dado    <= ZERO_A;
      valido  <= 1'b0;
      fim     <= 1'b0;
    end else begin
      fim <= 1'b0;
      case (state)
        IDLE: begin
          valido  <= 1'b0;
          address <= ZERO_A;
          if (start) begin
            state <= RUN;
          end
        end

        RUN: begin
          if (parar) begin
            // Stop takes priority over capture; the pending word (if any)
            // is still delivered from DRAIN.
            state <= DRAIN;
          end else if (cap) begin
            dado   <= saida;
            valido <= 1'b1;
            if (address == LAST_A) begin
              if (loop) begin
                address <= ZERO_A;
              end else begin
                state <= DRAIN;
              end
            end else begin
              address <= address + ONE_A;
            end
          end
        end

        DRAIN: begin
          if (cap) begin
            valido  <= 1'b0;
            address <= ZERO_A;
            fim     <= 1'b1;
            state   <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_player.sv
// Directed bench for seq_player with a ROM model saida = address ^ 4'hA.
// u_dut uses LAST=15, u_dut0 uses LAST=0.
module tb_seq_player;

  logic       clk;
  logic       rst_n;
  logic       start, loop, parar, pronto;
  logic [3:0] address, saida, dado;
  logic       valido, ocupado, fim;

  logic       start0, loop0, parar0, pronto0;
  logic [3:0] address0, saida0, dado0;
  logic       valido0, ocupado0, fim0;

  int n_tests;
  int n_fail;

  assign saida  = address ^ 4'hA;
  assign saida0 = address0 ^ 4'hA;

  seq_player #(.SIZE(4), .LAST(15)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .loop(loop), .parar(parar),
    .address(address), .saida(saida), .dado(dado), .valido(valido),
    .pronto(pronto), .ocupado(ocupado), .fim(fim)
  );

  seq_player #(.SIZE(4), .LAST(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .loop(loop0), .parar(parar0),
    .address(address0), .saida(saida0), .dado(dado0), .valido(valido0),
    .pronto(pronto0), .ocupado(ocupado0), .fim(fim0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int         acc;
    bit         seen;
    bit         prev_stall;
    logic [3:0] pd, pa;
    bit         p;

    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0;
    start = 0; loop = 0; parar = 0; pronto = 0;
    start0 = 0; loop0 = 0; parar0 = 0; pronto0 = 0;

    // ---- reset state
    #12;
    check("rst address", int'(address), 0);
    check("rst dado", int'(dado), 0);
    check("rst valido", int'(valido), 0);
    check("rst fim", int'(fim), 0);
    check("rst ocupado", int'(ocupado), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // ---- test 1: one-shot, pronto held high
    pronto = 1; start = 1;
    tick();                                   // E0
    start = 0;
    check("t1 ocupado E0", int'(ocupado), 1);
    check("t1 valido E0", int'(valido), 0);
    check("t1 address E0", int'(address), 0);
    tick();                                   // E1: first capture
    for (int i = 0; i < 16; i++) begin
      check("t1 valido", int'(valido), 1);
      check("t1 word", int'(dado), i ^ 10);
      check("t1 fim early", int'(fim), 0);
      tick();
    end
    check("t1 valido end", int'(valido), 0);
    check("t1 fim pulse", int'(fim), 1);
    check("t1 ocupado end", int'(ocupado), 0);
    check("t1 address end", int'(address), 0);
    check("t1 dado held", int'(dado), 5);
    tick();
    check("t1 fim one cycle", int'(fim), 0);

    // ---- test 2: one-shot, pronto toggling pseudo-randomly
    start = 1;
    tick();
    start = 0;
    acc = 0; seen = 0; prev_stall = 0; pd = '0; pa = '0;
    for (int c = 0; c < 300 && !seen; c++) begin
      if (fim) begin
        seen = 1;
      end else begin
        if (prev_stall) begin
          check("t2 stall dado", int'(dado), int'(pd));
          check("t2 stall address", int'(address), int'(pa));
        end
        p = 1'($urandom_range(0, 1));
        pronto = p;
        if (valido && p) begin
          check("t2 word", int'(dado), (acc % 16) ^ 10);
          acc++;
        end
        prev_stall = valido && !p;
        pd = dado;
        pa = address;
        tick();
      end
    end
    check("t2 words accepted", acc, 16);
    check("t2 fim seen", int'(seen), 1);
    tick();
    check("t2 fim one cycle", int'(fim), 0);
    check("t2 ocupado end", int'(ocupado), 0);

    // ---- test 3: looping, pronto high, wraps without a bubble
    pronto = 1; loop = 1; start = 1;
    tick();
    start = 0;
    tick();
    for (int i = 0; i < 40; i++) begin
      check("t3 no bubble", int'(valido), 1);
      check("t3 word", int'(dado), (i % 16) ^ 10);
      check("t3 no fim", int'(fim), 0);
      tick();
    end
    pronto = 0; parar = 1;
    tick();
    parar = 0;
    check("t3 drain valido", int'(valido), 1);
    check("t3 drain no fim", int'(fim), 0);
    pronto = 1;
    tick();
    check("t3 stop fim", int'(fim), 1);
    loop = 0;
    tick();

    // ---- test 4: parar after third accepted word while pronto low
    pronto = 1; start = 1;
    tick();
    start = 0;
    tick();
    for (int i = 0; i < 3; i++) begin
      check("t4 word", int'(dado), i ^ 10);
      tick();
    end
    pronto = 0; parar = 1;
    tick();
    parar = 0;
    for (int i = 0; i < 3; i++) begin
      check("t4 pending valido", int'(valido), 1);
      check("t4 pending dado", int'(dado), 9);
      check("t4 pending fim", int'(fim), 0);
      tick();
    end
    pronto = 1;
    tick();
    check("t4 fim", int'(fim), 1);
    check("t4 valido off", int'(valido), 0);
    check("t4 address", int'(address), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t4 no more words", int'(valido), 0);
      check("t4 idle", int'(ocupado), 0);
    end

    // ---- test 5: asynchronous reset mid-run
    pronto = 1; start = 1;
    tick();
    start = 0;
    tick();
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("t5 valido", int'(valido), 0);
    check("t5 dado", int'(dado), 0);
    check("t5 address", int'(address), 0);
    check("t5 ocupado", int'(ocupado), 0);
    check("t5 fim", int'(fim), 0);
    tick();
    check("t5 fim held", int'(fim), 0);
    rst_n = 1'b1;
    tick();
    start = 1;
    tick();
    start = 0;
    tick();
    check("t5 restart valido", int'(valido), 1);
    check("t5 restart word", int'(dado), 10);
    seen = 0;
    for (int c = 0; c < 40 && !seen; c++) begin
      tick();
      if (fim) seen = 1;
    end
    check("t5 completes", int'(seen), 1);

    // ---- test 6: LAST=0, start ignored while busy
    pronto0 = 0; start0 = 1;
    tick();
    start0 = 0;
    tick();
    check("t6 valido", int'(valido0), 1);
    check("t6 word", int'(dado0), 10);
    check("t6 address", int'(address0), 0);
    start0 = 1;
    tick();
    start0 = 0;
    check("t6 busy ocupado", int'(ocupado0), 1);
    check("t6 busy dado", int'(dado0), 10);
    check("t6 busy fim", int'(fim0), 0);
    pronto0 = 1;
    tick();
    check("t6 fim", int'(fim0), 1);
    check("t6 valido off", int'(valido0), 0);
    tick();
    check("t6 fim one cycle", int'(fim0), 0);
    check("t6 stays idle", int'(ocupado0), 0);
    check("t6 no restart", int'(valido0), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_player.md
Name: seq_player

Overview:
- Sequencer stage that sits directly upstream of the 4-bit sequence ROMs (seq_00 family, port names address/saida).
- Drives the ROM address, captures the ROM's combinational output into a registered word, and presents it downstream with a valid/ready handshake.
- Supports one-shot or looping playback, a stop request, and back-pressure.

Parameters:
- SIZE, 4, width of address and data (must match the ROM).
- LAST, 15, last address played before wrap or end; range 0..2^SIZE-1.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin playback; sampled only in IDLE.
- loop  input  1  at LAST: 1 = wrap to 0, 0 = end; sampled at the LAST capture.
- parar  input  1  stop request; sampled in RUN.
- address  output  SIZE  ROM address (registered).
- saida  input  SIZE  ROM data for the current address (combinational from ROM).
- dado  output  SIZE  captured word to downstream.
- valido  output  1  dado is valid.
- pronto  input  1  downstream accepts dado when valido && pronto.
- ocupado  output  1  high whenever state != IDLE (combinational from state).
- fim  output  1  one-cycle pulse on return to IDLE.

Behaviour:
- One clock domain; reset is asynchronous and active-low.
- Reset (rst_n=0, async): state=IDLE, address=0, dado=0, valido=0, fim=0. Reset mid-playback aborts immediately; no fim pulse.
- States: IDLE, RUN, DRAIN.
- Capture condition cap = (!valido || pronto).
- IDLE:
  - valido=0, address=0.
  - start=1 -> RUN next edge; address stays 0.
- RUN, evaluated in priority order:
  1. parar=1 -> DRAIN; no capture this edge; address holds.
  2. cap=1 -> dado<=saida, valido<=1, then:
     - address==LAST and loop=1: address<=0, stay in RUN.
     - address==LAST and loop=0: -> DRAIN, address holds.
     - otherwise: address<=address+1.
  3. cap=0 (stalled) -> dado, address and valido hold.
- DRAIN:
  - If valido=1 and pronto=0: hold.
  - If valido=0, or valido=1 with pronto=1: valido<=0, address<=0, fim<=1, -> IDLE.
- fim: registered; high exactly one cycle, the first cycle in IDLE.
- Latency: start sampled at edge E0 -> RUN after E0 -> first capture at E1 -> valido=1 after E1, with dado = ROM[0].
- Throughput: with pronto held high, one word per cycle and no bubbles, including across a loop wrap.
- Word order: ROM[0], ROM[1], ... ROM[LAST]. The word at each address is captured exactly once per pass and never skipped or duplicated under arbitrary pronto patterns.
- Address arithmetic: SIZE bits, increment only; never exceeds LAST.
- start while ocupado=1: ignored.
- start and parar together in IDLE: start wins; parar is ignored in IDLE.
- LAST=0: each pass plays a single word, ROM[0].
- dado holds its last value after valido drops; it is not cleared.
- The loop input is ignored except at the LAST capture.

Test Plan (bench ROM model: saida = address ^ 4'hA):
- Reset then start pulse, pronto=1, loop=0, LAST=15 -> valido high 2 edges after start sampled; 16 consecutive words 0xA,0xB,0x8,...,0x5; then valido=0, fim one-cycle pulse, ocupado=0, address=0.
- Same run with pronto toggling pseudo-randomly -> exactly 16 accepted words in the same order; dado/address stable whenever valido && !pronto.
- loop=1, pronto=1 for 40 cycles -> accepted stream wraps 0x5 -> 0xA without a bubble; fim never pulses.
- parar asserted after the 3rd accepted word while pronto=0 -> pending word 0x9 stays valid until pronto=1, is accepted, then fim pulses; no further words.
- rst_n driven low asynchronously mid-run (between edges) -> valido, dado and address go to 0 immediately; fim stays 0; a new start plays from 0xA.
- LAST=0, loop=0, start -> single word 0xA then fim; start pulses while ocupado=1 have no effect.
